cpu_host_sequencer: RTL and testbench

- Synthesizable host-side sequencer for the CPU/CGRA core: streams an instruction image byte by byte into the CPU instruction port, then waits a programmed run time.
- After the wait, it sweeps the vector-register readout port and compares each lane against golden data.
- It generalises the fixed 8-bit, 256-byte, 16-register by 4-lane load/check flow into a parametrised block, adding error counting, pass/fail status and restartable operation.
- Sits between the instruction/golden ROMs and the CPU top in FPGA bring-up builds.

---
 rtl/cpu_host_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_cpu_host_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_host_sequencer.sv
// Purpose: streams an instruction image into the CPU, waits a run time, then sweeps the vector readout port against golden data.
// Latency: 1 + INSTR_DEPTH + RUN_CYCLES + NUM_REGS*LANES cycles from start_i to done_o; mismatch_o lags its compare by one cycle.
// Backpressure: none; ROMs and CPU readout are combinational, start_i is ignored while busy_o=1. Optional HOST_ERR_LOG_EN adds first-error capture ports.
module cpu_host_sequencer #(
  parameter int DATA_W      = 8,
  parameter int INSTR_DEPTH = 256,
  parameter int RUN_CYCLES  = 234,
  parameter int NUM_REGS    = 16,
  parameter int LANES       = 4,
  parameter int BASE_REG    = 8,
  parameter int ADDR_W      = 5,
  parameter int ERR_W       = 8
) (
  input  logic                              clk_i,
  input  logic                              reset,
  input  logic                              start_i,
  output logic [$clog2(INSTR_DEPTH)-1:0]    irom_addr_o,
  input  logic [DATA_W-1:0]                 irom_data_i,
  output logic [$clog2(NUM_REGS*LANES)-1:0] gold_addr_o,
  input  logic [DATA_W-1:0]                 gold_data_i,
  output logic [DATA_W-1:0]                 instr_o,
  output logic                              data_or_reg_o,
  output logic [ADDR_W-1:0]                 reg_addr_o,
  output logic [$clog2(LANES)-1:0]          lane_addr_o,
  input  logic [DATA_W-1:0]                 value_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              pass_o,
  output logic                              mismatch_o,
  output logic [ERR_W-1:0]                  err_cnt_o
`ifdef HOST_ERR_LOG_EN
  ,
  output logic [$clog2(NUM_REGS*LANES)-1:0] first_err_idx_o,
  output logic [DATA_W-1:0]                 first_err_val_o
`endif
);

  localparam int NPAT  = NUM_REGS * LANES;
  localparam int IA_W  = $clog2(INSTR_DEPTH);
  localparam int G_W   = $clog2(NPAT);
  localparam int L_W   = $clog2(LANES);
  localparam int CMAX  = (INSTR_DEPTH > RUN_CYCLES) ? INSTR_DEPTH : RUN_CYCLES;
  localparam int CNT_W = $clog2(CMAX + 1);

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(INSTR_DEPTH);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [G_W-1:0]   J_LAST    = G_W'(NPAT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CHECK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [G_W-1:0]    j_q, j_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              mismatch_q, mismatch_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              mis_now;
`ifdef HOST_ERR_LOG_EN
  logic [G_W-1:0]    fidx_q, fidx_d;
  logic [DATA_W-1:0] fval_q, fval_d;
`endif

  // Next-state and datapath: LOAD counts one extra cycle so the last ROM byte is shown before instr_o drops to 0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    j_d        = j_q;
    instr_d    = instr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    mis_now    = 1'b0;
`ifdef HOST_ERR_LOG_EN
    fidx_d     = fidx_q;
    fval_d     = fval_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          j_d     = '0;
          instr_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
`ifdef HOST_ERR_LOG_EN
          fidx_d  = '0;
          fval_d  = '0;
`endif
        end
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          instr_d = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          instr_d = irom_data_i;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        instr_d = '0;
        if (cnt_q == RUN_LAST) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        mis_now    = (value_i != gold_data_i);
        mismatch_d = mis_now;
        if (mis_now && (err_q != ERR_MAX)) begin
          err_d = err_q + 1'b1;
        end
`ifdef HOST_ERR_LOG_EN
        // A saturated counter never returns to zero, so err_q==0 marks the first mismatch.
        if (mis_now && (err_q == '0)) begin
          fidx_d = j_q;
          fval_d = value_i;
        end
`endif
        if (j_q == J_LAST) begin
          j_d     = '0;
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any sequence without reporting a result.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      j_q        <= '0;
      instr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
`ifdef HOST_ERR_LOG_EN
      fidx_q     <= '0;
      fval_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      j_q        <= j_d;
      instr_q    <= instr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
`ifdef HOST_ERR_LOG_EN
      fidx_q     <= fidx_d;
      fval_q     <= fval_d;
`endif
    end
  end

  // Readout addresses derive from the pattern index; j_q idles at 0 so they rest at BASE_REG / top lane.
  assign irom_addr_o   = (state_q == S_LOAD) ? cnt_q[IA_W-1:0] : '0;
  assign gold_addr_o   = j_q;
  assign reg_addr_o    = ADDR_W'(BASE_REG) + ADDR_W'(j_q >> L_W);
  assign lane_addr_o   = L_W'(LANES - 1) - j_q[L_W-1:0];
  assign data_or_reg_o = 1'b1;
  assign instr_o       = instr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign mismatch_o    = mismatch_q;
  assign err_cnt_o     = err_q;
`ifdef HOST_ERR_LOG_EN
  assign first_err_idx_o = fidx_q;
  assign first_err_val_o = fval_q;
`endif

endmodule

// File: tb/tb_cpu_host_sequencer.sv
// Purpose: checks cpu_host_sequencer against a timeline model of load/run/check, using two instances (ERR_W=8 and ERR_W=2).
// Latency: model expects the first LOAD cycle right after the start edge; everything else is offset from there.
// Backpressure: none; ROMs and the CPU register file are combinational bench models.
module tb_cpu_host_sequencer;
  localparam int DEPTH  = 256;
  localparam int RUNC   = 234;
  localparam int NREG   = 16;
  localparam int LN     = 4;
  localparam int BASE   = 8;
  localparam int NPAT   = NREG * LN;
  localparam int CHK0   = DEPTH + 1 + RUNC;
  localparam int DONE_C = CHK0 + NPAT;

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic [NPAT-1:0] corrupt_v;
  int checks = 0;
  int errors = 0;

  logic [7:0] irom_addr_a, irom_addr_b;
  logic [5:0] gold_addr_a, gold_addr_b;
  logic [7:0] instr_a, instr_b, value_a, value_b;
  logic       dor_a, dor_b;
  logic [4:0] reg_a, reg_b;
  logic [1:0] lane_a, lane_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, mis_a, mis_b;
  logic [7:0] err_a;
  logic [1:0] err_b;
`ifdef HOST_ERR_LOG_EN
  logic [5:0] fidx_a, fidx_b;
  logic [7:0] fval_a, fval_b;
`endif

  function automatic logic [7:0] gold_fn(int p);
    return 8'((p * 37 + 11) & 255);
  endfunction

  // CPU register file: reg BASE+r lane l holds the golden value of pattern r*LN + (LN-1-l).
  function automatic logic [7:0] cpu_val(logic [4:0] r, logic [1:0] l, logic [NPAT-1:0] cv);
    int p;
    if (int'(r) < BASE || int'(r) >= BASE + NREG) return 8'hEE;
    p = (int'(r) - BASE) * LN + (LN - 1 - int'(l));
    return gold_fn(p) ^ (cv[p] ? 8'h5A : 8'h00);
  endfunction

  assign value_a = cpu_val(reg_a, lane_a, corrupt_v);
  assign value_b = gold_fn(int'(gold_addr_b)) ^ 8'hFF;

  cpu_host_sequencer dut_a (
    .clk_i(clk), .reset(rst), .start_i(start),
    .irom_addr_o(irom_addr_a), .irom_data_i(irom_addr_a),
    .gold_addr_o(gold_addr_a), .gold_data_i(gold_fn(int'(gold_addr_a))),
    .instr_o(instr_a), .data_or_reg_o(dor_a), .reg_addr_o(reg_a), .lane_addr_o(lane_a),
    .value_i(value_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .mismatch_o(mis_a), .err_cnt_o(err_a)
`ifdef HOST_ERR_LOG_EN
    , .first_err_idx_o(fidx_a), .first_err_val_o(fval_a)
`endif
  );

  cpu_host_sequencer #(.ERR_W(2)) dut_b (
    .clk_i(clk), .reset(rst), .start_i(start),
    .irom_addr_o(irom_addr_b), .irom_data_i(irom_addr_b),
    .gold_addr_o(gold_addr_b), .gold_data_i(gold_fn(int'(gold_addr_b))),
    .instr_o(instr_b), .data_or_reg_o(dor_b), .reg_addr_o(reg_b), .lane_addr_o(lane_b),
    .value_i(value_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .mismatch_o(mis_b), .err_cnt_o(err_b)
`ifdef HOST_ERR_LOG_EN
    , .first_err_idx_o(fidx_b), .first_err_val_o(fval_b)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycle index since start plus accumulated error counts.
  int         mt;
  bit         mact;
  int         merr_a, merr_b;
  bit         mmis_a, mmis_b;
  int         mfidx;
  logic [7:0] mfval;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mact = 0; mt = 0; merr_a = 0; merr_b = 0; mmis_a = 0; mmis_b = 0; mfidx = 0; mfval = 8'h00;
    end else if (start && !(mact && mt < DONE_C)) begin
      mact = 1; mt = 0; merr_a = 0; merr_b = 0; mmis_a = 0; mmis_b = 0; mfidx = 0; mfval = 8'h00;
    end else if (mact) begin
      mmis_a = 0;
      mmis_b = 0;
      if (mt >= CHK0 && mt < DONE_C) begin
        if (corrupt_v[mt - CHK0]) begin
          if (merr_a == 0) begin
            mfidx = mt - CHK0;
            mfval = gold_fn(mt - CHK0) ^ 8'h5A;
          end
          merr_a = (merr_a < 255) ? merr_a + 1 : 255;
          mmis_a = 1;
        end
        merr_b = (merr_b < 3) ? merr_b + 1 : 3;
        mmis_b = 1;
      end
      if (mt < 100000) mt++;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int  j;
    bit  e_done;
    e_done = mact && mt >= DONE_C;
    chk("instr_a", instr_a, (mact && mt >= 1 && mt <= DEPTH) ? 32'(mt - 1) : 32'd0);
    chk("instr_b", instr_b, (mact && mt >= 1 && mt <= DEPTH) ? 32'(mt - 1) : 32'd0);
    chk("busy_a", busy_a, 32'(mact && mt < DONE_C));
    chk("busy_b", busy_b, 32'(mact && mt < DONE_C));
    chk("done_a", done_a, 32'(e_done));
    chk("done_b", done_b, 32'(e_done));
    chk("pass_a", pass_a, 32'(e_done && merr_a == 0));
    chk("pass_b", pass_b, 32'(e_done && merr_b == 0));
    chk("mis_a", mis_a, 32'(mmis_a));
    chk("mis_b", mis_b, 32'(mmis_b));
    chk("err_a", err_a, 32'(merr_a));
    chk("err_b", err_b, 32'(merr_b));
    chk("dor_a", dor_a, 32'd1);
`ifdef HOST_ERR_LOG_EN
    chk("fidx_a", fidx_a, 32'(mfidx));
    chk("fval_a", fval_a, 32'(mfval));
`endif
    if (mact && mt < DEPTH) chk("irom_addr", irom_addr_a, 32'(mt));
    if (mact && mt >= CHK0 && mt < DONE_C) begin
      j = mt - CHK0;
      chk("reg_addr", reg_a, 32'(BASE + j / LN));
      chk("lane_addr", lane_a, 32'(LN - 1 - j % LN));
      chk("gold_addr", gold_addr_a, 32'(j));
      chk("reg_addr_b", reg_b, 32'(BASE + j / LN));
    end else if (!mact) begin
      chk("rst_reg", reg_a, 32'(BASE));
      chk("rst_lane", lane_a, 32'(LN - 1));
    end
  end

  int mis_cnt = 0;
  always @(negedge clk) if (mis_a === 1'b1) mis_cnt++;

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_mt(input int target);
    int n;
    n = 0;
    while (!(mact && mt == target) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("wait_mt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (done_a !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    if (BASE + NREG - 1 >= 32) begin
      $display("FAIL base_fit register range exceeds address width");
      $fatal(1, "bad parameters");
    end
    rst = 1'b1; start = 1'b0; corrupt_v = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy_a, 32'd0);
    chk("reset_lane", lane_a, 32'd3);
    chk("reset_reg", reg_a, 32'd8);
    rst = 1'b0;

    // Clean sequence: all golden.
    pulse_start();
    wait_mt(256);
    chk("lit_last_byte", instr_a, 32'hFF);
    @(negedge clk);
    chk("lit_run_zero", instr_a, 32'h00);
    wait_mt(CHK0);
    chk("lit_first_reg", reg_a, 32'd8);
    chk("lit_first_lane", lane_a, 32'd3);
    wait_mt(CHK0 + 63);
    chk("lit_last_reg", reg_a, 32'd23);
    chk("lit_last_lane", lane_a, 32'd0);
    wait_done();
    chk("lit_clean_pass", pass_a, 32'd1);
    chk("lit_clean_err", err_a, 32'd0);
    chk("lit_sat_err", err_b, 32'd3);
    chk("lit_sat_pass", pass_b, 32'd0);

    // Corrupt patterns 5 and 63, plus an ignored start during RUN.
    corrupt_v[5] = 1'b1;
    corrupt_v[63] = 1'b1;
    repeat (2) @(negedge clk);
    mis_cnt = 0;
    pulse_start();
    wait_mt(300);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("lit_done_at", mt, 32'(DONE_C));
    @(negedge clk);
    chk("lit_mis_pulses", mis_cnt, 32'd2);
    chk("lit_err2", err_a, 32'd2);
    chk("lit_fail_pass", pass_a, 32'd0);
`ifdef HOST_ERR_LOG_EN
    chk("lit_first_idx", fidx_a, 32'd5);
`endif

    // Reset during CHECK at j=20, then a clean rerun.
    corrupt_v = '0;
    pulse_start();
    wait_mt(CHK0 + 20);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy_a, 32'd0);
    chk("abort_done", done_a, 32'd0);
    chk("abort_err", err_a, 32'd0);
    chk("abort_reg", reg_a, 32'd8);
    #2 rst = 1'b0;
    pulse_start();
    wait_done();
    chk("rerun_pass", pass_a, 32'd1);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
